// File: rtl/addr_walk_gen.sv
// rtl/addr_walk_gen.sv - tile address walker: one descriptor in, one address per beat out
//
// Walks every (row, col) of a tile and streams addr = offset + row*col_dim + col.
// Strength-reduced: the row base is a register that advances by col_dim each
// row, and the column step is a plain increment, so no multiplier is needed.
// All arithmetic wraps mod 2^ADDR_W.
//
// Optional feature macro: ADDR_WALK_COL_MAJOR_EN
//   defined   -> cfg_col_major port exists; column-major walk selectable per tile
//   undefined -> row-major walk only
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   cfg_valid/ready descriptor handshake (ready only while idle and not in reset)
//   cfg_offset      tile base address
//   cfg_col_dim     row pitch in words
//   cfg_rows        rows to walk
//   cfg_cols        columns per row
//   cfg_col_major   column-major select (ADDR_WALK_COL_MAJOR_EN only)
//   addr_valid/ready address beat handshake
//   addr            generated address
//   addr_last       marks the final beat of the tile
//   busy            walker is not idle
//   done            one-cycle pulse after the tile completes

module addr_walk_gen #(
  parameter int ADDR_W = 16,
  parameter int ROW_W  = 8,
  parameter int COL_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ADDR_W-1:0] cfg_offset,
  input  logic [ADDR_W-1:0] cfg_col_dim,
  input  logic [ROW_W-1:0]  cfg_rows,
  input  logic [COL_W-1:0]  cfg_cols,
`ifdef ADDR_WALK_COL_MAJOR_EN
  input  logic              cfg_col_major,
`endif
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_last,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [ROW_W-1:0]  ROW_ONE  = {{(ROW_W-1){1'b0}}, 1'b1};
  localparam logic [COL_W-1:0]  COL_ONE  = {{(COL_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [1:0]        state_q;

  // latched descriptor
  logic [ADDR_W-1:0] col_dim_q;
  logic [ROW_W-1:0]  rows_q;
  logic [COL_W-1:0]  cols_q;

  // walk position and running bases
  logic [ROW_W-1:0]  r_q;
  logic [COL_W-1:0]  c_q;
  logic [ADDR_W-1:0] row_base_q;
  logic [ADDR_W-1:0] addr_q;
  logic              addr_valid_q;
  logic              addr_last_q;

`ifdef ADDR_WALK_COL_MAJOR_EN
  logic              col_major_q;
  logic [ADDR_W-1:0] col_base_q;
  logic [ADDR_W-1:0] step_col_base;
`endif

  // position, bases and address of the beat that follows the current one
  logic [ROW_W-1:0]  step_r;
  logic [COL_W-1:0]  step_c;
  logic [ADDR_W-1:0] step_row_base;
  logic [ADDR_W-1:0] step_addr;
  logic              step_last;

  logic              cfg_accept;
  logic              cfg_zero;

  // cfg_ready drops during the reset cycle itself so nothing is accepted
  // on the edge that clears the walker.
  assign cfg_ready  = (state_q == S_IDLE) && !rst;
  assign cfg_accept = cfg_valid && cfg_ready;
  assign cfg_zero   = (cfg_rows == '0) || (cfg_cols == '0);

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_FIN);
  assign addr_valid = addr_valid_q;
  assign addr       = addr_q;
  assign addr_last  = addr_last_q;

  always_comb begin
    step_r        = r_q;
    step_c        = c_q;
    step_row_base = row_base_q;
    step_addr     = addr_q;
`ifdef ADDR_WALK_COL_MAJOR_EN
    step_col_base = col_base_q;
    if (col_major_q) begin
      // inner loop runs down a column; wrapping to the next column restarts
      // from col_base+1 rather than undoing the accumulated col_dim steps
      if (r_q != rows_q - ROW_ONE) begin
        step_r    = r_q + ROW_ONE;
        step_addr = addr_q + col_dim_q;
      end else begin
        step_r        = '0;
        step_c        = c_q + COL_ONE;
        step_col_base = col_base_q + ADDR_ONE;
        step_addr     = col_base_q + ADDR_ONE;
      end
    end else
`endif
    begin
      // inner loop runs along a row; a row wrap jumps to the next row base
      if (c_q != cols_q - COL_ONE) begin
        step_c    = c_q + COL_ONE;
        step_addr = addr_q + ADDR_ONE;
      end else begin
        step_c        = '0;
        step_r        = r_q + ROW_ONE;
        step_row_base = row_base_q + col_dim_q;
        step_addr     = row_base_q + col_dim_q;
      end
    end
    // the final beat sits at the far corner in either walk order
    step_last = (step_r == rows_q - ROW_ONE) && (step_c == cols_q - COL_ONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      col_dim_q    <= '0;
      rows_q       <= '0;
      cols_q       <= '0;
      r_q          <= '0;
      c_q          <= '0;
      row_base_q   <= '0;
      addr_q       <= '0;
      addr_valid_q <= 1'b0;
      addr_last_q  <= 1'b0;
`ifdef ADDR_WALK_COL_MAJOR_EN
      col_major_q  <= 1'b0;
      col_base_q   <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cfg_accept) begin
            col_dim_q  <= cfg_col_dim;
            rows_q     <= cfg_rows;
            cols_q     <= cfg_cols;
            r_q        <= '0;
            c_q        <= '0;
            row_base_q <= cfg_offset;
            addr_q     <= cfg_offset;
`ifdef ADDR_WALK_COL_MAJOR_EN
            col_major_q <= cfg_col_major;
            col_base_q  <= cfg_offset;
`endif
            if (cfg_zero) begin
              // empty tile: no beats, straight to the done pulse
              state_q <= S_FIN;
            end else begin
              state_q      <= S_RUN;
              addr_valid_q <= 1'b1;
              addr_last_q  <= (cfg_rows == ROW_ONE) && (cfg_cols == COL_ONE);
            end
          end
        end

        S_RUN: begin
          // everything holds while the consumer stalls
          if (addr_ready) begin
            if (addr_last_q) begin
              state_q      <= S_FIN;
              addr_valid_q <= 1'b0;
              addr_last_q  <= 1'b0;
            end else begin
              r_q         <= step_r;
              c_q         <= step_c;
              row_base_q  <= step_row_base;
              addr_q      <= step_addr;
              addr_last_q <= step_last;
`ifdef ADDR_WALK_COL_MAJOR_EN
              col_base_q  <= step_col_base;
`endif
            end
          end
        end

        S_FIN: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q      <= S_IDLE;
          addr_valid_q <= 1'b0;
          addr_last_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addr_walk_gen.sv
// tb/tb_addr_walk_gen.sv - self-checking bench for addr_walk_gen

module tb_addr_walk_gen;

  logic        clk;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_offset;
  logic [15:0] cfg_col_dim;
  logic [7:0]  cfg_rows;
  logic [9:0]  cfg_cols;
`ifdef ADDR_WALK_COL_MAJOR_EN
  logic        cfg_col_major;
`endif
  logic        addr_valid;
  logic        addr_ready;
  logic [15:0] addr;
  logic        addr_last;
  logic        busy;
  logic        done;

  int total;
  int bad;

  // {last, addr}
  logic [16:0] exp_q[$];

  addr_walk_gen #(.ADDR_W(16), .ROW_W(8), .COL_W(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_offset  (cfg_offset),
    .cfg_col_dim (cfg_col_dim),
    .cfg_rows    (cfg_rows),
    .cfg_cols    (cfg_cols),
`ifdef ADDR_WALK_COL_MAJOR_EN
    .cfg_col_major(cfg_col_major),
`endif
    .addr_valid  (addr_valid),
    .addr_ready  (addr_ready),
    .addr        (addr),
    .addr_last   (addr_last),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference model: direct multiply form of the address equation
  task automatic push_tile(input logic [15:0] off, input logic [15:0] dim,
                           input int rows, input int cols, input bit cm);
    logic [15:0] a;
    logic        l;
    if (!cm) begin
      for (int r = 0; r < rows; r++)
        for (int c = 0; c < cols; c++) begin
          a = off + dim * 16'(r) + 16'(c);
          l = (r == rows - 1) && (c == cols - 1);
          exp_q.push_back({l, a});
        end
    end else begin
      for (int c = 0; c < cols; c++)
        for (int r = 0; r < rows; r++) begin
          a = off + dim * 16'(r) + 16'(c);
          l = (r == rows - 1) && (c == cols - 1);
          exp_q.push_back({l, a});
        end
    end
  endtask

  // Issues one descriptor and drains the tile against the scoreboard.
  // stall=1 drives addr_ready as 1,0,0,1,0,0,...
  // fin_k is the loop index at which done was first seen (-1 if never).
  task automatic run_tile(input string name, input logic [15:0] off, input logic [15:0] dim,
                          input logic [7:0] rows, input logic [9:0] cols, input bit cm,
                          input bit stall, output int beats, output int fin_k);
    logic [16:0] e;
    logic [15:0] prev_addr;
    logic        prev_last;
    bit          prev_stall;
    push_tile(off, dim, int'(rows), int'(cols), cm);
    for (int i = 0; i < 50 && cfg_ready !== 1'b1; i++) tick();
    total++;
    if (cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s cfg_ready_wait: got %b want 1", name, cfg_ready);
    end
    cfg_offset  = off;
    cfg_col_dim = dim;
    cfg_rows    = rows;
    cfg_cols    = cols;
`ifdef ADDR_WALK_COL_MAJOR_EN
    cfg_col_major = cm;
`endif
    cfg_valid   = 1'b1;
    tick();
    cfg_valid   = 1'b0;
    beats = 0;
    fin_k = -1;
    prev_stall = 1'b0;
    prev_addr  = '0;
    prev_last  = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (done === 1'b1) begin
        fin_k = k;
        break;
      end
      addr_ready = stall ? ((k % 3) == 0) : 1'b1;
      if (prev_stall) begin
        total++;
        if (addr_valid !== 1'b1 || addr !== prev_addr || addr_last !== prev_last) begin
          bad++;
          $display("FAIL %s stall_hold: got valid=%b addr=%h last=%b want valid=1 addr=%h last=%b",
                   name, addr_valid, addr, addr_last, prev_addr, prev_last);
        end
      end
      if (addr_valid === 1'b1 && addr_ready === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL %s extra_beat: got addr=%h want no beat", name, addr);
        end else begin
          e = exp_q.pop_front();
          if ({addr_last, addr} !== e) begin
            bad++;
            $display("FAIL %s beat%0d: got addr=%h last=%b want addr=%h last=%b",
                     name, beats, addr, addr_last, e[15:0], e[16]);
          end
        end
        beats++;
      end
      prev_stall = (addr_valid === 1'b1) && !addr_ready;
      prev_addr  = addr;
      prev_last  = addr_last;
      tick();
    end
    addr_ready = 1'b1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s missing_beats: got %0d left want 0", name, exp_q.size());
    end
    exp_q.delete();
    total++;
    if (fin_k < 0) begin
      bad++;
      $display("FAIL %s done_timeout: got no done want done pulse", name);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({cfg_ready, addr_valid, addr_last, busy, done} !== 5'b0 || addr !== 16'h0) begin
      bad++;
      $display("FAIL reset_state: got rdy=%b v=%b last=%b busy=%b done=%b addr=%h want all 0",
               cfg_ready, addr_valid, addr_last, busy, done, addr);
    end
    rst = 1'b0;
    tick();
    total++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got rdy=%b busy=%b want rdy=1 busy=0", cfg_ready, busy);
    end
  endtask

  task automatic test_row_major();
    int beats, fin_k;
    run_tile("row_major", 16'h0100, 16'd16, 8'd2, 10'd3, 1'b0, 1'b0, beats, fin_k);
    total++;
    if (beats !== 6 || fin_k !== 6) begin
      bad++;
      $display("FAIL row_major_timing: got beats=%0d done_at=%0d want beats=6 done_at=6", beats, fin_k);
    end
    total++;
    if (busy !== 1'b1 || cfg_ready !== 1'b0 || addr_valid !== 1'b0) begin
      bad++;
      $display("FAIL row_major_fin: got busy=%b rdy=%b v=%b want 1 0 0", busy, cfg_ready, addr_valid);
    end
    tick();
    total++;
    if (done !== 1'b0 || cfg_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL row_major_idle: got done=%b rdy=%b busy=%b want 0 1 0", done, cfg_ready, busy);
    end
  endtask

  task automatic test_stall();
    int beats, fin_k;
    run_tile("stall", 16'h0100, 16'd16, 8'd2, 10'd3, 1'b0, 1'b1, beats, fin_k);
    total++;
    if (beats !== 6) begin
      bad++;
      $display("FAIL stall_count: got %0d want 6", beats);
    end
    tick();
  endtask

  task automatic test_zero_size();
    int beats, fin_k;
    run_tile("zero", 16'h0200, 16'd8, 8'd0, 10'd5, 1'b0, 1'b0, beats, fin_k);
    total++;
    if (beats !== 0 || fin_k !== 0 || addr_valid !== 1'b0) begin
      bad++;
      $display("FAIL zero_done: got beats=%0d done_at=%0d v=%b want 0 0 0", beats, fin_k, addr_valid);
    end
    tick();
    total++;
    if (cfg_ready !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL zero_ready: got rdy=%b done=%b want 1 0", cfg_ready, done);
    end
  endtask

  task automatic test_wrap();
    int beats, fin_k;
    run_tile("wrap", 16'hFFFE, 16'd1, 8'd1, 10'd4, 1'b0, 1'b0, beats, fin_k);
    tick();
  endtask

  task automatic test_back_to_back();
    int beats, fin_k;
    run_tile("b2b_a", 16'h1000, 16'd100, 8'd3, 10'd1, 1'b0, 1'b0, beats, fin_k);
    run_tile("b2b_b", 16'h2000, 16'h0040, 8'd1, 10'd1, 1'b0, 1'b0, beats, fin_k);
    run_tile("b2b_c", 16'hFF00, 16'h0080, 8'd3, 10'd2, 1'b0, 1'b1, beats, fin_k);
    tick();
  endtask

  task automatic test_rst_mid();
    int beats, fin_k;
    bit saw_done;
    cfg_offset  = 16'h0100;
    cfg_col_dim = 16'd16;
    cfg_rows    = 8'd2;
    cfg_cols    = 10'd3;
`ifdef ADDR_WALK_COL_MAJOR_EN
    cfg_col_major = 1'b0;
`endif
    addr_ready  = 1'b1;
    cfg_valid   = 1'b1;
    tick();
    cfg_valid   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (addr_valid !== 1'b1 || addr !== 16'h0100 + 16'(i)) begin
        bad++;
        $display("FAIL rst_mid_beat%0d: got v=%b addr=%h want v=1 addr=%h", i, addr_valid, addr, 16'h0100 + 16'(i));
      end
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (addr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_clear: got v=%b busy=%b done=%b want 0 0 0", addr_valid, busy, done);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1) saw_done = 1'b1;
      tick();
    end
    total++;
    if (saw_done) begin
      bad++;
      $display("FAIL rst_mid_done: got done pulse want none");
    end
    run_tile("rst_mid_new", 16'h0300, 16'd16, 8'd1, 10'd2, 1'b0, 1'b0, beats, fin_k);
    tick();
  endtask

`ifdef ADDR_WALK_COL_MAJOR_EN
  task automatic test_col_major();
    int beats, fin_k;
    run_tile("col_major", 16'h0100, 16'd16, 8'd2, 10'd3, 1'b1, 1'b0, beats, fin_k);
    tick();
    run_tile("col_major_stall", 16'h0FF0, 16'd8, 8'd3, 10'd2, 1'b1, 1'b1, beats, fin_k);
    tick();
  endtask
`endif

  initial begin
    total       = 0;
    bad         = 0;
    rst         = 1'b1;
    cfg_valid   = 1'b0;
    cfg_offset  = '0;
    cfg_col_dim = '0;
    cfg_rows    = '0;
    cfg_cols    = '0;
`ifdef ADDR_WALK_COL_MAJOR_EN
    cfg_col_major = 1'b0;
`endif
    addr_ready  = 1'b1;
    test_reset();
    test_row_major();
    test_stall();
    test_zero_size();
    test_wrap();
    test_back_to_back();
    test_rst_mid();
`ifdef ADDR_WALK_COL_MAJOR_EN
    test_col_major();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
